// File: rtl/dh_pkg.sv
// -----------------------------------------------------------------------------
// dh_pkg
// Shared tempo table for the Drums Hero game core. Holds the default system
// clock frequency and the three level rates, so every game block paces notes
// from the same numbers. Also provides the half-period helper and the level
// encoding used by the rhythm-clock generator.
// No ports (package).
// -----------------------------------------------------------------------------
package dh_pkg;

   localparam int unsigned DH_CLK_HZ = 32'd50_000_000;
   localparam int unsigned DH_RATE1  = 32'd32;
   localparam int unsigned DH_RATE2  = 32'd48;
   localparam int unsigned DH_RATE3  = 32'd64;

   typedef enum logic [1:0] {
      LVL1 = 2'd0,
      LVL2 = 2'd1,
      LVL3 = 2'd2
   } level_e;

   // Number of system clock cycles in one half of the output period
   // (integer truncation).
   function automatic int unsigned half_period(input int unsigned clk_hz,
                                               input int unsigned rate);
      return clk_hz / (32'd2 * rate);
   endfunction

endpackage

// File: rtl/clock_32pps_if.sv
// -----------------------------------------------------------------------------
// clock_32pps_if
// Control/output bundle of the rhythm-clock generator.
//   stop   : 1 freezes the generator (asynchronous source)
//   nivel2 : selects level 2 (asynchronous source)
//   nivel3 : selects level 3, priority over nivel2 (asynchronous source)
//   clk32  : divided square wave
// master : game control side (drives stop/nivel*, observes clk32)
// slave  : the generator
// -----------------------------------------------------------------------------
interface clock_32pps_if;

   logic stop;
   logic nivel2;
   logic nivel3;
   logic clk32;

   modport master (output stop, output nivel2, output nivel3, input clk32);
   modport slave  (input stop, input nivel2, input nivel3, output clk32);

endinterface

// File: rtl/clock_32pps_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous level signal.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops load RST_VAL
//   i_d   : asynchronous input
//   o_q   : synchronised output (registered)
// -----------------------------------------------------------------------------
module sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/clock_32pps.sv
// -----------------------------------------------------------------------------
// clock_32pps
// Programmable rhythm-clock generator. Divides clk down to a 50 % duty square
// wave clk32 at RATE1/RATE2/RATE3 Hz depending on the selected level; stop
// freezes it low.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of clock_32pps_if (stop, nivel2, nivel3 in; clk32 out)
// -----------------------------------------------------------------------------
module clock_32pps
   import dh_pkg::*;
#(
   parameter int unsigned CLK_HZ = DH_CLK_HZ,
   parameter int unsigned RATE1  = DH_RATE1,
   parameter int unsigned RATE2  = DH_RATE2,
   parameter int unsigned RATE3  = DH_RATE3
) (
   input  logic            clk,
   input  logic            rst_n,
   clock_32pps_if.slave    bus
);

   localparam int unsigned HALF1 = half_period(CLK_HZ, RATE1);
   localparam int unsigned HALF2 = half_period(CLK_HZ, RATE2);
   localparam int unsigned HALF3 = half_period(CLK_HZ, RATE3);
   // Level 1 has the longest half-period, so it sizes the counter.
   localparam int unsigned W     = $clog2(HALF1);

   localparam logic [W-1:0] LIM1     = W'(HALF1 - 32'd1);
   localparam logic [W-1:0] LIM2     = W'(HALF2 - 32'd1);
   localparam logic [W-1:0] LIM3     = W'(HALF3 - 32'd1);
   localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
   localparam logic [W-1:0] CNT_ONE  = W'(32'd1);

   logic         w_stop_s;
   logic         w_n2_s;
   logic         w_n3_s;
   level_e       w_level;
   logic [W-1:0] w_limit;
   logic [W-1:0] r_cnt;
   logic         r_clk32;

   // stop resets to 1 so the output stays frozen until stop is seen low.
   sync2 #(.RST_VAL(1'b1)) u_sync_stop (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (bus.stop),
      .o_q   (w_stop_s)
   );

   sync2 #(.RST_VAL(1'b0)) u_sync_n2 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (bus.nivel2),
      .o_q   (w_n2_s)
   );

   sync2 #(.RST_VAL(1'b0)) u_sync_n3 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (bus.nivel3),
      .o_q   (w_n3_s)
   );

   // Level select: level 3 wins over level 2.
   always_comb begin
      w_level = LVL1;
      if (w_n3_s) begin
         w_level = LVL3;
      end else if (w_n2_s) begin
         w_level = LVL2;
      end else begin
         w_level = LVL1;
      end
   end

   // Terminal count of the selected level.
   always_comb begin
      w_limit = LIM1;
      case (w_level)
         LVL1:    w_limit = LIM1;
         LVL2:    w_limit = LIM2;
         LVL3:    w_limit = LIM3;
         default: w_limit = LIM1;
      endcase
   end

   // Half-period counter and output toggle. The >= test lets a switch to a
   // faster level with the count already past the new limit toggle on the
   // next edge instead of running through 2^W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= CNT_ZERO;
         r_clk32 <= 1'b0;
      end else if (w_stop_s) begin
         r_cnt   <= CNT_ZERO;
         r_clk32 <= 1'b0;
      end else if (r_cnt >= w_limit) begin
         r_cnt   <= CNT_ZERO;
         r_clk32 <= ~r_clk32;
      end else begin
         r_cnt   <= r_cnt + CNT_ONE;
      end
   end

   assign bus.clk32 = r_clk32;

endmodule

// File: tb/tb_clock_32pps.sv
// -----------------------------------------------------------------------------
// tb_clock_32pps
// Self-checking bench for clock_32pps with CLK_HZ = 1920 (half-periods
// 30 / 20 / 15 cycles). A behavioural model predicts clk32 every cycle;
// directed scenarios measure phase lengths against hand-computed values.
// -----------------------------------------------------------------------------
module tb_clock_32pps;

   localparam int TB_CLK_HZ = 1920;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   clock_32pps_if bus_if ();

   clock_32pps #(.CLK_HZ(TB_CLK_HZ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit model_on = 1'b0;

   // Model state: input values as seen at the last two edges, the number of
   // edges already spent in the current output phase, and the output level.
   bit m_stop_q0, m_stop_q1;
   bit m_n2_q0,   m_n2_q1;
   bit m_n3_q0,   m_n3_q1;
   int m_age;
   bit m_clk;

   function automatic int half_for(input bit n2, input bit n3);
      int rate;
      rate = n3 ? 64 : (n2 ? 48 : 32);
      return TB_CLK_HZ / (2 * rate);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model plus the every-cycle comparison of clk32.
   always @(posedge clk or negedge rst_n) begin
      bit eff_stop;
      int h;
      if (!rst_n) begin
         m_stop_q0 = 1'b1; m_stop_q1 = 1'b1;
         m_n2_q0 = 1'b0;   m_n2_q1 = 1'b0;
         m_n3_q0 = 1'b0;   m_n3_q1 = 1'b0;
         m_age = 0;
         m_clk = 1'b0;
      end else begin
         // The generator acts on what the inputs were two edges ago.
         eff_stop = m_stop_q1;
         h = half_for(m_n2_q1, m_n3_q1);
         m_stop_q1 = m_stop_q0; m_stop_q0 = bus_if.stop;
         m_n2_q1 = m_n2_q0;     m_n2_q0 = bus_if.nivel2;
         m_n3_q1 = m_n3_q0;     m_n3_q0 = bus_if.nivel3;
         if (eff_stop) begin
            m_age = 0;
            m_clk = 1'b0;
         end else if (m_age + 1 >= h) begin
            // This edge completes the phase (possibly overdue after a level change).
            m_age = 0;
            m_clk = ~m_clk;
         end else begin
            m_age++;
         end
      end
      #1;
      if (model_on) check("model_clk32", int'(bus_if.clk32), int'(m_clk));
   end

   // Count edges until clk32 reads v (sampled 1 time unit after each edge).
   task automatic count_until(input logic v, output int n);
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (bus_if.clk32 === v) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL timeout: clk32 never reached %0b within %0d edges", v, n);
   endtask

   initial begin
      int n;
      bus_if.stop   = 1'b1;
      bus_if.nivel2 = 1'b0;
      bus_if.nivel3 = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_on = 1'b1;

      // Pin the model's half-period table.
      check("half1", half_for(1'b0, 1'b0), 30);
      check("half2", half_for(1'b1, 1'b0), 20);
      check("half3", half_for(1'b1, 1'b1), 15);

      // 1: stop held after reset.
      repeat (100) @(posedge clk);
      #1;
      check("stop_hold_clk32", int'(bus_if.clk32), 0);

      // 2: release stop at level 1.
      bus_if.stop = 1'b0;
      count_until(1'b1, n); check("first_rise_l1", n, 32);
      for (int i = 0; i < 5; i++) begin
         count_until(1'b0, n); check("l1_high", n, 30);
         count_until(1'b1, n); check("l1_low", n, 30);
      end

      // 3: level 2, then level 3 with level 2 still set.
      bus_if.nivel2 = 1'b1;
      count_until(1'b0, n);
      count_until(1'b1, n);
      count_until(1'b0, n); check("l2_high", n, 20);
      count_until(1'b1, n); check("l2_low", n, 20);
      bus_if.nivel3 = 1'b1;
      count_until(1'b0, n);
      count_until(1'b1, n);
      count_until(1'b0, n); check("l3_high", n, 15);
      count_until(1'b1, n); check("l3_low", n, 15);

      // 4: back to level 1, then jump to level 3 with cnt = 25.
      bus_if.nivel2 = 1'b0;
      bus_if.nivel3 = 1'b0;
      count_until(1'b0, n);
      count_until(1'b1, n);
      count_until(1'b0, n);
      count_until(1'b1, n);
      check("l1_again_low", n, 30);
      repeat (23) @(posedge clk);
      #1;
      bus_if.nivel3 = 1'b1;
      count_until(1'b0, n); check("overdue_toggle", n, 3);
      count_until(1'b1, n); check("after_jump_low", n, 15);
      count_until(1'b0, n); check("after_jump_high", n, 15);

      // 5: stop during a high phase, then release.
      count_until(1'b1, n);
      repeat (2) @(posedge clk);
      #1;
      bus_if.stop = 1'b1;
      count_until(1'b0, n); check("stop_latency", n, 3);
      repeat (10) @(posedge clk);
      #1;
      check("stop_frozen", int'(bus_if.clk32), 0);
      bus_if.stop = 1'b0;
      count_until(1'b1, n); check("restart_rise", n, 17);
      count_until(1'b0, n); check("restart_high", n, 15);

      // 6: asynchronous reset in the middle of a high phase.
      count_until(1'b1, n);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("reset_async", int'(bus_if.clk32), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      count_until(1'b1, n); check("post_reset_rise", n, 17);
      count_until(1'b0, n); check("post_reset_high", n, 15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
